// File: rtl/fa_tag_alloc_if.sv
// Lookup, refill, flush and LRU-link signals of the fully associative tag allocator.
// Signal names are from the allocator's point of view.
interface fa_tag_alloc_if #(
    parameter int TAG_W = 20
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic [TAG_W-1:0] i_req_tag;
    logic             o_rsp_valid;
    logic             o_rsp_hit;
    logic [2:0]       o_rsp_way;
    logic             o_refill_req;
    logic [TAG_W-1:0] o_refill_tag;
    logic             i_refill_done;
    logic             i_flush;
    logic             o_lru_update;
    logic [2:0]       o_lru_index;
    logic [2:0]       i_lru_victim;

    modport slave (
        input  i_req_valid, i_req_tag, i_refill_done,
        input  i_flush, i_lru_victim,
        output o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_way,
        output o_refill_req, o_refill_tag, o_lru_update, o_lru_index
    );

    modport master (
        output i_req_valid, i_req_tag, i_refill_done,
        output i_flush, i_lru_victim,
        input  o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_way,
        input  o_refill_req, o_refill_tag, o_lru_update, o_lru_index
    );
endinterface

// File: rtl/fa_tag_alloc.sv
// Fully associative 8-way tag store with miss refill and LRU touch generation.
// Victim is the lowest invalid way, otherwise the way reported by the LRU block.
module fa_tag_alloc #(
    parameter int TAG_W = 20,
    parameter int WAYS  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fa_tag_alloc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           r_state;
    logic [TAG_W-1:0] r_tag_q;
    logic [2:0]       r_victim;
    logic [WAYS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tags [WAYS];
    logic             r_flush_pend;
    logic             r_rsp_valid;
    logic             r_rsp_hit;
    logic [2:0]       r_rsp_way;
    logic             r_refill_req;
    logic             r_lru_update;
    logic [2:0]       r_lru_index;

    logic             w_hit;
    logic [2:0]       w_hit_way;
    logic             w_has_inv;
    logic [2:0]       w_inv_way;
    logic [2:0]       w_victim;
    logic             w_flush_now;

    // Scan high to low so the lowest matching / invalid way is the one kept.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 3'd0;
        w_has_inv = 1'b0;
        w_inv_way = 3'd0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tags[i] == r_tag_q)) begin
                w_hit     = 1'b1;
                w_hit_way = 3'(i);
            end
            if (!r_valid[i]) begin
                w_has_inv = 1'b1;
                w_inv_way = 3'(i);
            end
        end
        w_victim = w_has_inv ? w_inv_way : bus.i_lru_victim;
    end

    assign w_flush_now = bus.i_flush | r_flush_pend;

    assign bus.o_req_ready  = (r_state == IDLE) & ~w_flush_now;
    assign bus.o_rsp_valid  = r_rsp_valid;
    assign bus.o_rsp_hit    = r_rsp_hit;
    assign bus.o_rsp_way    = r_rsp_way;
    assign bus.o_refill_req = r_refill_req;
    assign bus.o_refill_tag = r_tag_q;
    assign bus.o_lru_update = r_lru_update;
    assign bus.o_lru_index  = r_lru_index;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_tag_q      <= '0;
            r_victim     <= 3'd0;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_way    <= 3'd0;
            r_refill_req <= 1'b0;
            r_lru_update <= 1'b0;
            r_lru_index  <= 3'd0;
            for (int i = 0; i < WAYS; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_rsp_valid  <= 1'b0;
            r_lru_update <= 1'b0;
            // A flush seen while busy is remembered until the FSM is idle again.
            if (bus.i_flush && (r_state != IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_flush_now) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (bus.i_req_valid) begin
                        r_tag_q <= bus.i_req_tag;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_hit    <= 1'b1;
                        r_rsp_way    <= w_hit_way;
                        r_lru_update <= 1'b1;
                        r_lru_index  <= w_hit_way;
                        r_state      <= RESP;
                    end else begin
                        r_victim     <= w_victim;
                        r_refill_req <= 1'b1;
                        r_state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.i_refill_done) begin
                        r_tags[r_victim]  <= r_tag_q;
                        r_valid[r_victim] <= 1'b1;
                        r_refill_req      <= 1'b0;
                        r_rsp_valid       <= 1'b1;
                        r_rsp_hit         <= 1'b0;
                        r_rsp_way         <= r_victim;
                        r_lru_update      <= 1'b1;
                        r_lru_index       <= r_victim;
                        r_state           <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
